// File: rtl/mips_sec_alu_if.sv
// mips_sec_alu_if: control-unit <-> secondary ALU signal bundle.
// The master side (control unit / bench) drives enable, op code and operands.
// The slave side (mips_sec_alu) returns the result, busy, stall and unimpl flags.
interface mips_sec_alu_if #(
    parameter int DW = 32
);
    logic          i_en;
    logic [2:0]    i_op;
    logic [DW-1:0] i_a;
    logic [DW-1:0] i_b;
    logic [DW-1:0] o_result;
    logic          o_busy;
    logic          o_stall;
    logic          o_unimpl;

    modport master (
        output i_en, i_op, i_a, i_b,
        input  o_result, o_busy, o_stall, o_unimpl
    );

    modport slave (
        input  i_en, i_op, i_a, i_b,
        output o_result, o_busy, o_stall, o_unimpl
    );
endinterface

// File: rtl/mips_sec_alu.sv
// mips_sec_alu: multi-cycle HI/LO unit for the MIPS core.
// It executes MULT/MULTU with a shift-add multiplier and DIV/DIVU with a
// restoring divider, one bit per cycle, followed by a sign-fix cycle.
// It also handles MTHI/MTLO/MFHI/MFLO.
// Optional feature macro: SEC_ALU_DIV_EN. When it is undefined, the divider
// is removed and DIV/DIVU only pulse o_unimpl.
module mips_sec_alu #(
    parameter int DW = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    mips_sec_alu_if.slave   bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIX
`ifdef SEC_ALU_DIV_EN
        , S_DIV
`endif
    } state_t;

    state_t          r_state, w_next;
    logic [DW-1:0]   r_hi, r_lo;
    logic [DW-1:0]   r_ma, r_mb;        // operand magnitudes; r_ma doubles as quotient
    logic [2*DW-1:0] r_acc;             // product, or remainder in the low half
    logic [CW-1:0]   r_cnt;
    logic            r_neg;             // product / quotient negate flag

    logic            w_busy, w_accept, w_signed, w_is_mul;
    logic [DW-1:0]   w_amag, w_bmag;
    logic [DW:0]     w_msum;
    logic [2*DW-1:0] w_prod;

    assign w_busy   = (r_state != S_IDLE);
    assign w_accept = bus.i_en & ~w_busy;
    assign w_signed = ~bus.i_op[0];
    assign w_is_mul = (bus.i_op[2:1] == 2'b10);
    assign w_amag   = (w_signed & bus.i_a[DW-1]) ? -bus.i_a : bus.i_a;
    assign w_bmag   = (w_signed & bus.i_b[DW-1]) ? -bus.i_b : bus.i_b;

    // The product's low bits shift in from the top as the multiplier is consumed.
    assign w_msum = {1'b0, r_acc[2*DW-1:DW]} + (r_mb[0] ? {1'b0, r_ma} : {(DW+1){1'b0}});
    assign w_prod = r_neg ? -r_acc : r_acc;

`ifdef SEC_ALU_DIV_EN
    logic            r_isdiv, r_rneg, r_dz;
    logic [DW-1:0]   r_araw;            // dividend as issued, returned on divide-by-zero
    logic            w_is_div, w_dge;
    logic [DW:0]     w_dsh, w_ddiff;
    logic [DW-1:0]   w_drem, w_quo, w_rem;

    assign w_is_div = (bus.i_op[2:1] == 2'b11);
    assign w_dsh    = {r_acc[DW-1:0], r_ma[DW-1]};
    assign w_ddiff  = w_dsh - {1'b0, r_mb};
    assign w_dge    = (w_dsh >= {1'b0, r_mb});
    assign w_drem   = w_dge ? w_ddiff[DW-1:0] : w_dsh[DW-1:0];
    assign w_quo    = r_neg  ? -r_ma : r_ma;
    assign w_rem    = r_rneg ? -r_acc[DW-1:0] : r_acc[DW-1:0];
    assign bus.o_unimpl = 1'b0;
`else
    logic            r_unimpl;
    assign bus.o_unimpl = r_unimpl;

    // An accepted DIV/DIVU gives a one-cycle unimplemented pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_unimpl <= 1'b0;
        else       r_unimpl <= w_accept & (bus.i_op[2:1] == 2'b11);
    end
`endif

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: run DW iterations, then one fix-up cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept & w_is_mul) w_next = S_MUL;
`ifdef SEC_ALU_DIV_EN
                else if (w_accept & w_is_div) w_next = S_DIV;
`endif
            end
            S_MUL:   if (r_cnt == CW'(DW-1)) w_next = S_FIX;
`ifdef SEC_ALU_DIV_EN
            S_DIV:   if (r_cnt == CW'(DW-1)) w_next = S_FIX;
`endif
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate, write HI/LO in FIX.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_ma  <= '0;
            r_mb  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_neg <= 1'b0;
`ifdef SEC_ALU_DIV_EN
            r_isdiv <= 1'b0;
            r_rneg  <= 1'b0;
            r_dz    <= 1'b0;
            r_araw  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    if (bus.i_op == 3'b001) r_hi <= bus.i_a;
                    if (bus.i_op == 3'b011) r_lo <= bus.i_a;
                    if (w_is_mul) begin
                        r_ma  <= w_amag;
                        r_mb  <= w_bmag;
                        r_neg <= w_signed & (bus.i_a[DW-1] ^ bus.i_b[DW-1]);
                        r_acc <= '0;
                        r_cnt <= '0;
`ifdef SEC_ALU_DIV_EN
                        r_isdiv <= 1'b0;
`endif
                    end
`ifdef SEC_ALU_DIV_EN
                    if (w_is_div) begin
                        r_ma    <= w_amag;
                        r_mb    <= w_bmag;
                        r_neg   <= w_signed & (bus.i_a[DW-1] ^ bus.i_b[DW-1]);
                        r_rneg  <= w_signed & bus.i_a[DW-1];
                        r_dz    <= (bus.i_b == '0);
                        r_araw  <= bus.i_a;
                        r_isdiv <= 1'b1;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
`endif
                end
                S_MUL: begin
                    r_acc <= {w_msum, r_acc[DW-1:1]};
                    r_mb  <= r_mb >> 1;
                    r_cnt <= r_cnt + CW'(1);
                end
`ifdef SEC_ALU_DIV_EN
                S_DIV: begin
                    r_acc <= {{DW{1'b0}}, w_drem};
                    r_ma  <= {r_ma[DW-2:0], w_dge};
                    r_cnt <= r_cnt + CW'(1);
                end
`endif
                S_FIX: begin
`ifdef SEC_ALU_DIV_EN
                    if (r_isdiv) begin
                        r_lo <= r_dz ? {DW{1'b1}} : w_quo;
                        r_hi <= r_dz ? r_araw : w_rem;
                    end else
`endif
                    begin
                        r_hi <= w_prod[2*DW-1:DW];
                        r_lo <= w_prod[DW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy   = w_busy;
    assign bus.o_stall  = bus.i_en & w_busy;
    assign bus.o_result = (bus.i_op == 3'b000) ? r_hi :
                          (bus.i_op == 3'b010) ? r_lo : '0;
endmodule

// File: tb/tb_mips_sec_alu.sv
// tb_mips_sec_alu: table of mul/div vectors with hand-computed HI/LO, plus
// hand-written sequences for MTHI/MTLO, a stalled MFLO, and reset mid-multiply.
module tb_mips_sec_alu;
`ifdef SEC_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_sec_alu_if #(.DW(32)) bus();
    mips_sec_alu #(.DW(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t        vt[12];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nb, nu;
        logic nodiv;
        logic [31:0] eh, el;
        nodiv = (v.op[2:1] == 2'b11) && !DIV_EN;
        @(negedge clk);
        bus.i_en = 1'b1; bus.i_op = v.op; bus.i_a = v.a; bus.i_b = v.b;
        @(posedge clk); #1;
        bus.i_en = 1'b0;
        nb = 0; nu = 0;
        if (bus.o_busy)   nb++;
        if (bus.o_unimpl) nu++;
        for (int g = 0; g < 100 && bus.o_busy; g++) begin
            @(posedge clk); #1;
            if (bus.o_busy)   nb++;
            if (bus.o_unimpl) nu++;
        end
        @(posedge clk); #1;
        if (bus.o_unimpl) nu++;
        eh = nodiv ? m_hi : v.hi;
        el = nodiv ? m_lo : v.lo;
        chk($sformatf("v%0d busy_cycles", idx), 32'(nb), nodiv ? 32'd0 : 32'd33);
        chk($sformatf("v%0d unimpl_pulses", idx), 32'(nu), nodiv ? 32'd1 : 32'd0);
        @(negedge clk);
        bus.i_en = 1'b1; bus.i_op = 3'b000; #1;
        chk($sformatf("v%0d MFHI", idx), bus.o_result, eh);
        bus.i_op = 3'b010; #1;
        chk($sformatf("v%0d MFLO", idx), bus.o_result, el);
        bus.i_en = 1'b0;
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        int nb, ns;
        vt[0]  = '{3'b100, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vt[1]  = '{3'b101, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
        vt[2]  = '{3'b100, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vt[3]  = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[4]  = '{3'b100, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vt[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[6]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[7]  = '{3'b111, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vt[8]  = '{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vt[9]  = '{3'b111, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vt[10] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vt[11] = '{3'b101, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        rst = 1'b1;
        bus.i_en = 1'b0; bus.i_op = 3'b000; bus.i_a = '0; bus.i_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst busy", 32'(bus.o_busy), 32'd0);
        chk("rst unimpl", 32'(bus.o_unimpl), 32'd0);
        chk("rst MFHI", bus.o_result, 32'd0);
        bus.i_op = 3'b010; #1;
        chk("rst MFLO", bus.o_result, 32'd0);
        bus.i_op = 3'b100; #1;
        chk("result for non-MF op", bus.o_result, 32'd0);

        // MTHI then MTLO on consecutive cycles.
        @(negedge clk);
        bus.i_en = 1'b1; bus.i_op = 3'b001; bus.i_a = 32'h12345678; #1;
        chk("MTHI stall", 32'(bus.o_stall), 32'd0);
        @(negedge clk);
        bus.i_op = 3'b011; bus.i_a = 32'h9ABCDEF0; #1;
        chk("MTLO stall", 32'(bus.o_stall), 32'd0);
        @(negedge clk);
        bus.i_op = 3'b000; #1;
        chk("MTHI readback", bus.o_result, 32'h12345678);
        bus.i_op = 3'b010; #1;
        chk("MTLO readback", bus.o_result, 32'h9ABCDEF0);
        bus.i_en = 1'b0;
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

        for (int i = 0; i < 12; i++) run_vec(i, vt[i]);

        // MULTU followed by an MFLO held against the stall.
        @(negedge clk);
        bus.i_en = 1'b1; bus.i_op = 3'b101; bus.i_a = 32'hFFFFFFFE; bus.i_b = 32'h3;
        @(posedge clk); #1;
        bus.i_op = 3'b010;
        nb = 0; ns = 0;
        for (int g = 0; g < 100 && bus.o_busy; g++) begin
            nb++;
            if (bus.o_stall) ns++;
            @(posedge clk); #1;
        end
        chk("b2b busy_cycles", 32'(nb), 32'd33);
        chk("b2b stall_cycles", 32'(ns), 32'd33);
        chk("b2b stall released", 32'(bus.o_stall), 32'd0);
        chk("b2b MFLO", bus.o_result, 32'hFFFFFFFA);
        bus.i_op = 3'b000; #1;
        chk("b2b MFHI", bus.o_result, 32'h00000002);
        bus.i_en = 1'b0;

        // Reset in the middle of a MULT.
        @(negedge clk);
        bus.i_en = 1'b1; bus.i_op = 3'b100; bus.i_a = 32'd5; bus.i_b = 32'd7;
        @(posedge clk); #1;
        bus.i_en = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_en = 1'b1; bus.i_op = 3'b000; #1;
        chk("abort HI", bus.o_result, 32'd0);
        bus.i_op = 3'b010; #1;
        chk("abort LO", bus.o_result, 32'd0);
        bus.i_op = 3'b011; bus.i_a = 32'd5; #1;
        chk("abort MTLO stall", 32'(bus.o_stall), 32'd0);
        @(posedge clk); #1;
        bus.i_op = 3'b010; #1;
        chk("abort MTLO readback", bus.o_result, 32'd5);
        bus.i_en = 1'b0;

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
